// File: rtl/fpgaaudio_keys_pio_in.sv
// Avalon-MM parallel input port for push-buttons/switches: per-bit synchroniser,
// debouncer, sticky edge capture with write-1-to-clear, and a masked level irq.
`timescale 1ns/1ps

module fpgaaudio_keys_pio_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? '1 : '0;

  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear_bits;
  logic [CW-1:0]    count [WIDTH];
  logic             wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d <= IDLE_VEC;
      sync_q <= IDLE_VEC;
    end else begin
      sync_d <= in_port;
      sync_q <= sync_d;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      if ((sync_q[i] != stable[i]) && (count[i] == CNT_LAST)) begin
        stable_next[i] = sync_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= IDLE_VEC;
      for (int i = 0; i < WIDTH; i++) begin
        count[i] <= '0;
      end
    end else begin
      stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_LAST) begin
          count[i] <= '0;
        end else begin
          count[i] <= count[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edges = ~stable & stable_next;
      1:       edges = stable & ~stable_next;
      default: edges = stable ^ stable_next;
    endcase
  end

  // Bus: zero-wait-state; a write is accepted on any clk edge where chipselect is
  // high and write_n low; readdata is a pure function of address and registers.
  assign wr_en      = chipselect & ~write_n;
  assign clear_bits = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (address == 2'd2)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // Set after clear, so an edge arriving with its clear is kept.
      edge_capture <= (edge_capture & ~clear_bits) | edges;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_writedata;
      assign unused_writedata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_fpgaaudio_keys_pio_in.sv
// Bench for fpgaaudio_keys_pio_in: falling-edge and any-edge instances share the bus
// and pins; a window-based reference model predicts stable level, captures and irq.
`timescale 1ns/1ps

module tb_fpgaaudio_keys_pio_in;

  localparam int WIDTH = 4;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = '1;
  logic [31:0]      rd_f, rd_a;
  logic             irq_f, irq_a;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpgaaudio_keys_pio_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1), .IDLE_LEVEL(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f)
  );

  fpgaaudio_keys_pio_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2), .IDLE_LEVEL(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  // Reference model: a level is accepted once the pin, seen two cycles late,
  // has shown the opposite level for the last DB samples.
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] m_stable, m_mask, m_cap_f, m_cap_a;
  logic [WIDTH-1:0] m_nxt, m_clr, m_newmask;
  bit               m_acc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      for (int j = 0; j < DB + 2; j++) hist.push_back('1);
      m_stable <= '1;
      m_mask   <= '0;
      m_cap_f  <= '0;
      m_cap_a  <= '0;
    end else begin
      hist.push_back(in_port);
      if (hist.size() > DB + 2) void'(hist.pop_front());
      m_nxt = m_stable;
      for (int b = 0; b < WIDTH; b++) begin
        m_acc = 1'b1;
        for (int j = 0; j < DB; j++) begin
          if (hist[j][b] == m_stable[b]) m_acc = 1'b0;
        end
        if (m_acc) m_nxt[b] = ~m_stable[b];
      end
      m_clr = '0;
      m_newmask = m_mask;
      if (chipselect && !write_n) begin
        if (address == 2'd2) m_newmask = writedata[WIDTH-1:0];
        if (address == 2'd3) m_clr = writedata[WIDTH-1:0];
      end
      m_mask   <= m_newmask;
      m_cap_f  <= (m_cap_f & ~m_clr) | (m_stable & ~m_nxt);
      m_cap_a  <= (m_cap_a & ~m_clr) | (m_stable ^ m_nxt);
      m_stable <= m_nxt;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a, input bit any_edge);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd2:    return 32'(m_mask);
      2'd3:    return any_edge ? 32'(m_cap_a) : 32'(m_cap_f);
      default: return 32'h0;
    endcase
  endfunction

  // Callers sit at a negedge; the write lands on the next posedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = 4'hF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read(2'd0);
    checks++; if (rd_f !== 32'h0000000F) begin failures++; $display("FAIL reset_data got=%h want=%h", rd_f, 32'hF); end
    checks++; if (rd_a !== 32'h0000000F) begin failures++; $display("FAIL reset_data_any got=%h want=%h", rd_a, 32'hF); end
    read(2'd1);
    checks++; if (rd_f !== 32'h0) begin failures++; $display("FAIL reset_reserved got=%h want=0", rd_f); end
    read(2'd2);
    checks++; if (rd_f !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h want=0", rd_f); end
    read(2'd3);
    checks++; if (rd_f !== 32'h0) begin failures++; $display("FAIL reset_capture got=%h want=0", rd_f); end
    checks++; if (irq_f !== 1'b0 || irq_a !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b%b want=00", irq_f, irq_a); end
  endtask

  task automatic test_fall_latency();
    logic exp;
    in_port[0] = 1'b0;
    address = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      exp = (k < 6) ? 1'b1 : 1'b0;
      checks++; if (rd_f[0] !== exp) begin failures++; $display("FAIL fall_latency edge=%0d got=%b want=%b", k, rd_f[0], exp); end
    end
    @(negedge clk);
    read(2'd3);
    checks++; if (rd_f !== 32'h1) begin failures++; $display("FAIL fall_capture got=%h want=1", rd_f); end
    checks++; if (rd_a !== 32'h1) begin failures++; $display("FAIL fall_capture_any got=%h want=1", rd_a); end
    checks++; if (irq_f !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b want=0", irq_f); end
    bus_write(2'd2, 32'h1);
    checks++; if (irq_f !== 1'b1 || irq_a !== 1'b1) begin failures++; $display("FAIL irq_unmask got=%b%b want=11", irq_f, irq_a); end
    read(2'd2);
    checks++; if (rd_f !== 32'h1) begin failures++; $display("FAIL mask_read got=%h want=1", rd_f); end
  endtask

  task automatic test_glitch();
    in_port[1] = 1'b0;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b1;
    @(negedge clk);
    in_port[1] = 1'b0;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b1;
    repeat (8) @(negedge clk);
    read(2'd0);
    checks++; if (rd_f !== 32'hE || rd_f !== model_read(2'd0, 1'b0)) begin failures++; $display("FAIL glitch_data got=%h want=%h", rd_f, 32'hE); end
    read(2'd3);
    checks++; if (rd_f !== 32'h1) begin failures++; $display("FAIL glitch_capture got=%h want=1", rd_f); end
    checks++; if (rd_a !== 32'h1) begin failures++; $display("FAIL glitch_capture_any got=%h want=1", rd_a); end
  endtask

  task automatic test_clear();
    bus_write(2'd3, 32'h1);
    read(2'd3);
    checks++; if (rd_f !== 32'h0) begin failures++; $display("FAIL w1c_capture got=%h want=0", rd_f); end
    checks++; if (irq_f !== 1'b0) begin failures++; $display("FAIL w1c_irq got=%b want=0", irq_f); end
    in_port[0] = 1'b1;
    repeat (8) @(negedge clk);
    read(2'd3);
    checks++; if (rd_f !== 32'h0) begin failures++; $display("FAIL rise_ignored got=%h want=0", rd_f); end
    checks++; if (rd_a !== 32'h1) begin failures++; $display("FAIL rise_any got=%h want=1", rd_a); end
    bus_write(2'd3, 32'hF);
    // Fall of bit 0 reaches stable on the same edge as the clearing write.
    in_port[0] = 1'b0;
    repeat (5) @(negedge clk);
    bus_write(2'd3, 32'h1);
    read(2'd3);
    checks++; if (rd_f !== 32'h1) begin failures++; $display("FAIL set_beats_clear got=%h want=1", rd_f); end
    checks++; if (rd_a !== 32'h1) begin failures++; $display("FAIL set_beats_clear_any got=%h want=1", rd_a); end
    checks++; if (irq_f !== 1'b1) begin failures++; $display("FAIL set_beats_clear_irq got=%b want=1", irq_f); end
  endtask

  task automatic test_rise_type();
    bus_write(2'd3, 32'hF);
    in_port[2] = 1'b0;
    repeat (8) @(negedge clk);
    bus_write(2'd3, 32'hF);
    read(2'd0);
    checks++; if (rd_f !== 32'hA) begin failures++; $display("FAIL bit2_low got=%h want=a", rd_f); end
    checks++; if (irq_f !== 1'b0) begin failures++; $display("FAIL bit2_irq got=%b want=0", irq_f); end
    in_port[2] = 1'b1;
    repeat (8) @(negedge clk);
    read(2'd0);
    checks++; if (rd_f !== 32'hE) begin failures++; $display("FAIL bit2_high got=%h want=e", rd_f); end
    read(2'd3);
    checks++; if (rd_f !== 32'h0) begin failures++; $display("FAIL rise_falltype got=%h want=0", rd_f); end
    checks++; if (rd_a !== 32'h4) begin failures++; $display("FAIL rise_anytype got=%h want=4", rd_a); end
  endtask

  task automatic test_reset_mid();
    bus_write(2'd3, 32'hF);
    in_port[3] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    in_port = 4'hF;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    read(2'd0);
    checks++; if (rd_f !== 32'hF) begin failures++; $display("FAIL midreset_data got=%h want=f", rd_f); end
    read(2'd3);
    checks++; if (rd_f !== 32'h0 || rd_a !== 32'h0) begin failures++; $display("FAIL midreset_capture got=%h/%h want=0", rd_f, rd_a); end
    checks++; if (irq_f !== 1'b0 || irq_a !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b%b want=00", irq_f, irq_a); end
  endtask

  task automatic test_hold_through_reset();
    reset_n = 1'b0;
    in_port[3] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    read(2'd0);
    checks++; if (rd_f !== 32'h7) begin failures++; $display("FAIL held_data got=%h want=7", rd_f); end
    read(2'd3);
    checks++; if (rd_f !== 32'h8 || rd_a !== 32'h8) begin failures++; $display("FAIL held_capture got=%h/%h want=8", rd_f, rd_a); end
    in_port = 4'hF;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++; if (irq_f !== |(m_cap_f & m_mask)) begin failures++; $display("FAIL rand_irq cyc=%0d got=%b want=%b", c, irq_f, |(m_cap_f & m_mask)); end
      checks++; if (irq_a !== |(m_cap_a & m_mask)) begin failures++; $display("FAIL rand_irq_any cyc=%0d got=%b want=%b", c, irq_a, |(m_cap_a & m_mask)); end
      for (int b = 0; b < WIDTH; b++) begin
        if ($urandom_range(0, 4) == 0) in_port[b] = ~in_port[b];
      end
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom();
      end else begin
        chipselect = ($urandom_range(0, 1) == 1); write_n = 1'b1;
      end
      #1;
      checks++; if (rd_f !== model_read(address, 1'b0)) begin failures++; $display("FAIL rand_read cyc=%0d addr=%0d got=%h want=%h", c, address, rd_f, model_read(address, 1'b0)); end
      checks++; if (rd_a !== model_read(address, 1'b1)) begin failures++; $display("FAIL rand_read_any cyc=%0d addr=%0d got=%h want=%h", c, address, rd_a, model_read(address, 1'b1)); end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fall_latency();
    test_glitch();
    test_clear();
    test_rise_type();
    test_reset_mid();
    test_hold_through_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
